// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter placed after the ALU result bus. It
// converts the unsigned 2*Bits-bit ALU result into DIGITS packed decimal digits
// for the seven-segment decoders. It uses shift-and-add-3 (double dabble) and
// processes one bit per clock, so no divider is needed.
//
// A conversion starts from IDLE on `start`. It also starts when `auto_en` is
// set and `valor` differs from the last value accepted. A conversion takes
// 2*Bits cycles, and `done` pulses for one cycle when the result is published.
//
// Parameters:
//   Bits    ALU operand width; the converted value is 2*Bits bits wide.
//   DIGITS  number of BCD digits produced (digit 0 = units).
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   valor    [2*Bits-1:0]  unsigned binary value to convert
//   start    level-sampled conversion request, honoured only in IDLE
//   auto_en  1 = convert whenever `valor` differs from the last accepted value
//   busy     high while a conversion is in progress
//   done     one-cycle pulse when `bcd`/`ovf` carry a new result
//   bcd      [4*DIGITS-1:0] packed digits, bits [4i+3:4i] = digit i; held
//   ovf      1 = last converted value did not fit in DIGITS decimal digits
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int Bits   = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*Bits-1:0]     valor,
    input  logic                  start,
    input  logic                  auto_en,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int W  = 2 * Bits;
    localparam int BW = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q,  state_d;
    logic [W-1:0]    bin_q,    bin_d;     // binary half of the shift vector
    logic [BW-1:0]   dig_q,    dig_d;     // scratch digits, never visible on bcd
    logic [CW-1:0]   cnt_q,    cnt_d;     // bits shifted so far
    logic            sticky_q, sticky_d;  // a 1 has left the top digit
    logic [W-1:0]    ultimo_q, ultimo_d;  // last accepted value, for auto mode
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic [BW-1:0]   bcd_q,    bcd_d;
    logic            ovf_q,    ovf_d;

    logic [BW-1:0]   dig_adj;
    logic [BW-1:0]   dig_shift;
    logic            carry_out;
    logic            trigger;

    // NOTE: combinational logic uses blocking '=' so later statements see the
    // earlier results (dig_adj feeds dig_shift). The flop block below uses '<='.
    always_comb begin
        // NOTE: every signal gets a default value first. Without it, any path
        // through the case that skips an assignment would infer a latch.
        state_d  = state_q;
        bin_d    = bin_q;
        dig_d    = dig_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        ultimo_d = ultimo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        trigger  = 1'b0;

        // Add 3 to every digit that is 5 or more. A digit never exceeds 9
        // before this step, so the result always fits in 4 bits.
        dig_adj = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end

        // Shift {digits, binary} left by one. The bit leaving the top digit
        // would start digit DIGITS, so it marks an overflow.
        carry_out = dig_adj[BW-1];
        dig_shift = {dig_adj[BW-2:0], bin_q[W-1]};

        case (state_q)
            IDLE: begin
                trigger = start | (auto_en & (valor != ultimo_q));
                if (trigger) begin
                    bin_d    = valor;
                    ultimo_d = valor;
                    dig_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                dig_d    = dig_shift;
                bin_d    = {bin_q[W-2:0], 1'b0};
                sticky_d = sticky_q | carry_out;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    // Publish only the finished digits, so `bcd` never
                    // shows a partial result.
                    bcd_d   = dig_shift;
                    ovf_d   = sticky_q | carry_out;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            ultimo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            dig_q    <= dig_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            ultimo_q <= ultimo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Drives two converters from the same inputs. One has DIGITS=3 and never
// overflows on 8-bit values. The other has DIGITS=2 and covers the overflow
// and modulo behaviour.
//
// A behavioural model tracks when each conversion is accepted and finished.
// It computes the expected digits with plain divide/modulo arithmetic.
// Directed scenarios pin exact literal results and timing.
// Randomized traffic then runs against the model.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int Bits = 4;
    localparam int W    = 2 * Bits;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] valor = '0;
    logic         start = 1'b0;
    logic         auto_en = 1'b0;

    logic         busy3, done3, ovf3;
    logic [11:0]  bcd3;
    logic         busy2, done2, ovf2;
    logic [7:0]   bcd2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.Bits(Bits), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .valor(valor), .start(start), .auto_en(auto_en),
        .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3)
    );

    bin_to_bcd_seq #(.Bits(Bits), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .valor(valor), .start(start), .auto_en(auto_en),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Decimal digits of v, digit i in bits [4i+3:4i], keeping the low nd digits.
    function automatic logic [11:0] to_bcd(input int v, input int nd);
        logic [11:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // A conversion accepted on an edge finishes W edges later.
    // m_rem counts the edges still to go.
    int          m_rem  = 0;
    int          m_val  = 0;
    int          m_last = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [11:0] m_bcd3 = '0;
    logic [7:0]  m_bcd2 = '0;
    logic        m_ovf3 = 1'b0;
    logic        m_ovf2 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  = 0;
            m_last = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_bcd3 = '0;
            m_bcd2 = '0;
            m_ovf3 = 1'b0;
            m_ovf2 = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_bcd3 = to_bcd(m_val, 3);
                    m_bcd2 = 8'(to_bcd(m_val, 2));
                    m_ovf3 = (m_val >= 1000);
                    m_ovf2 = (m_val >= 100);
                end
            end else if (start || (auto_en && (int'(valor) != m_last))) begin
                m_val  = int'(valor);
                m_last = int'(valor);
                m_rem  = W;
            end
            m_busy = (m_rem > 0);
        end
    end

    // Compare every output of both instances on every falling edge.
    always @(negedge clk) begin
        check("busy3", 32'(busy3), 32'(m_busy));
        check("done3", 32'(done3), 32'(m_done));
        check("bcd3",  32'(bcd3),  32'(m_bcd3));
        check("ovf3",  32'(ovf3),  32'(m_ovf3));
        check("busy2", 32'(busy2), 32'(m_busy));
        check("done2", 32'(done2), 32'(m_done));
        check("bcd2",  32'(bcd2),  32'(m_bcd2));
        check("ovf2",  32'(ovf2),  32'(m_ovf2));
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done3 && n < 30);
        if (!done3) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy3 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy3) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // One started conversion from IDLE.
    // Checks the latency, the busy width and the literal results.
    task automatic do_conv(input logic [7:0] v, input logic [11:0] exp3,
                           input logic [7:0] exp2, input logic exp_ovf2);
        int n;
        int busy_cnt;
        @(negedge clk);
        valor = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt = busy3 ? 1 : 0;
        n = 0;
        while (!done3 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (busy3) busy_cnt++;
        end
        check($sformatf("lat_%0d", v), 32'(n), 32'd8);
        check($sformatf("busyw_%0d", v), 32'(busy_cnt), 32'd8);
        check($sformatf("bcd3_%0d", v), 32'(bcd3), 32'(exp3));
        check($sformatf("ovf3_%0d", v), 32'(ovf3), 32'd0);
        check($sformatf("bcd2_%0d", v), 32'(bcd2), 32'(exp2));
        check($sformatf("ovf2_%0d", v), 32'(ovf2), 32'(exp_ovf2));
    endtask

    int corner [8] = '{0, 9, 10, 99, 100, 128, 200, 255};

    initial begin
        int n;
        int n_done;
        int last_t;

        // Reset
        #1 rst = 1'b1;
        #21 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_done", 32'(done3), 32'd0);
        check("rst_bcd",  32'(bcd3),  32'd0);
        check("rst_ovf",  32'(ovf3),  32'd0);

        // 255 with a pulsed start
        do_conv(8'd255, 12'h255, 8'h55, 1'b1);

        // Sequence of values
        do_conv(8'd0,   12'h000, 8'h00, 1'b0);
        do_conv(8'd9,   12'h009, 8'h09, 1'b0);
        do_conv(8'd10,  12'h010, 8'h10, 1'b0);
        do_conv(8'd99,  12'h099, 8'h99, 1'b0);
        do_conv(8'd100, 12'h100, 8'h00, 1'b1);
        do_conv(8'd128, 12'h128, 8'h28, 1'b1);

        // start held high: one result every 9 cycles
        @(negedge clk);
        valor  = 8'd37;
        start  = 1'b1;
        n_done = 0;
        last_t = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done3) begin
                n_done++;
                check("hold_bcd", 32'(bcd3), 32'h037);
                if (last_t >= 0) check("hold_period", 32'(c - last_t), 32'd9);
                last_t = c;
            end
        end
        check("hold_count", 32'(n_done), 32'd4);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Auto mode: valor changes from 7 to 200 during busy
        @(negedge clk);
        valor   = 8'd7;
        auto_en = 1'b1;
        @(posedge clk);
        #1;
        check("auto_accept", 32'(busy3), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        valor = 8'd200;
        wait_done("auto1", n);
        check("auto1_bcd", 32'(bcd3), 32'h007);
        wait_done("auto2", n);
        check("auto_gap",  32'(n), 32'd9);
        check("auto2_bcd", 32'(bcd3), 32'h200);
        check("auto2_ovf2", 32'(ovf2), 32'd1);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done3) n_done++;
        end
        check("auto_quiet", 32'(n_done), 32'd0);
        @(negedge clk);
        auto_en = 1'b0;

        // Two-digit overflow and recovery
        do_conv(8'd150, 12'h150, 8'h50, 1'b1);
        do_conv(8'd42,  12'h042, 8'h42, 1'b0);

        // Reset three cycles into a conversion
        @(negedge clk);
        valor = 8'd255;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy3), 32'd0);
        check("mid_rst_done", 32'(done3), 32'd0);
        check("mid_rst_bcd",  32'(bcd3),  32'd0);
        check("mid_rst_bcd2", 32'(bcd2),  32'd0);
        check("mid_rst_ovf2", 32'(ovf2),  32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done3) n_done++;
        end
        check("mid_rst_nodone", 32'(n_done), 32'd0);
        do_conv(8'd255, 12'h255, 8'h55, 1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) valor = 8'(corner[$urandom_range(0, 7)]);
                else                           valor = 8'($urandom_range(0, 255));
            end
            start = ($urandom_range(0, 9) < 2);
            if (c % 200 == 0) auto_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        start   = 1'b0;
        auto_en = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
